seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for the 4-digit 7-segment display of the irrigation controller.
- Consumes the timer nibbles and status values produced by the counter/decode stage and drives SEG_D1..SEG_D4 plus segment lines SEG_A..SEG_P.
- Double-buffers display data so a frame never tears, inserts an anti-ghosting blank gap between digits, and emits a frame strobe.

---
 rtl/seg7_scan_driver_if.sv | 34 +++
 rtl/seg7_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - display data load bus and scan outputs for seg7_scan_driver
interface seg7_scan_driver_if;
    logic [15:0] Digits;
    logic [3:0]  Dp_in;
    logic [3:0]  Blank_in;
    logic        Load;
    logic        SEG_D1;
    logic        SEG_D2;
    logic        SEG_D3;
    logic        SEG_D4;
    logic        SEG_A;
    logic        SEG_B;
    logic        SEG_C;
    logic        SEG_D;
    logic        SEG_E;
    logic        SEG_F;
    logic        SEG_G;
    logic        SEG_P;
    logic        Frame_done;

    modport master (
        output Digits, Dp_in, Blank_in, Load,
        input  SEG_D1, SEG_D2, SEG_D3, SEG_D4,
        input  SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_P,
        input  Frame_done
    );

    modport slave (
        input  Digits, Dp_in, Blank_in, Load,
        output SEG_D1, SEG_D2, SEG_D3, SEG_D4,
        output SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_P,
        output Frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment driver, double-buffered, anti-ghost gap
module seg7_scan_driver #(
    parameter int PRESC       = 50000,
    parameter int GHOST       = 1000,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    seg7_scan_driver_if.slave  bus
);
    localparam int             CW      = $clog2(PRESC);
    localparam logic [CW-1:0]  LAST    = CW'(PRESC - 1);
    localparam logic [CW-1:0]  GHOST_C = CW'(GHOST);
    localparam logic           SEG_INV = (SEG_ACT_LOW != 0);
    localparam logic           DIG_INV = (DIG_ACT_LOW != 0);

    typedef enum logic {GAP, ON} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   pend_dig, pend_dig_nxt, act_dig, act_dig_nxt;
    logic [3:0]    pend_dp, pend_dp_nxt, act_dp, act_dp_nxt;
    logic [3:0]    pend_blank, pend_blank_nxt, act_blank, act_blank_nxt;
    logic          boundary, lit;
    logic [3:0]    nib;
    logic [3:0]    dig_nxt, dig_q;
    logic [6:0]    seg_nxt, seg_q;
    logic          dp_nxt, dp_q, frame_done;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b1111110;
            4'h1: decode = 7'b0110000;
            4'h2: decode = 7'b1101101;
            4'h3: decode = 7'b1111001;
            4'h4: decode = 7'b0110011;
            4'h5: decode = 7'b1011011;
            4'h6: decode = 7'b1011111;
            4'h7: decode = 7'b1110000;
            4'h8: decode = 7'b1111111;
            4'h9: decode = 7'b1111011;
            4'hA: decode = 7'b1110111;
            4'hB: decode = 7'b0011111;
            4'hC: decode = 7'b1001110;
            4'hD: decode = 7'b0111101;
            4'hE: decode = 7'b1001111;
            default: decode = 7'b1000111;
        endcase
    endfunction

    // Outputs are computed from next-cycle state so enables and segments land on the same edge.
    always_comb begin
        cnt_nxt        = cnt + 1'b1;
        idx_nxt        = idx;
        state_nxt      = state;
        pend_dig_nxt   = pend_dig;
        pend_dp_nxt    = pend_dp;
        pend_blank_nxt = pend_blank;
        act_dig_nxt    = act_dig;
        act_dp_nxt     = act_dp;
        act_blank_nxt  = act_blank;
        boundary       = (cnt == LAST) && (idx == 2'd3);

        if (cnt == LAST) begin
            cnt_nxt   = '0;
            idx_nxt   = idx + 2'd1;
            state_nxt = (GHOST_C == '0) ? ON : GAP;
        end else if (cnt_nxt == GHOST_C) begin
            state_nxt = ON;
        end

        if (bus.Load) begin
            pend_dig_nxt   = bus.Digits;
            pend_dp_nxt    = bus.Dp_in;
            pend_blank_nxt = bus.Blank_in;
        end
        if (boundary) begin
            act_dig_nxt   = pend_dig_nxt;
            act_dp_nxt    = pend_dp_nxt;
            act_blank_nxt = pend_blank_nxt;
        end

        case (idx_nxt)
            2'd0:    nib = act_dig_nxt[15:12];
            2'd1:    nib = act_dig_nxt[11:8];
            2'd2:    nib = act_dig_nxt[7:4];
            default: nib = act_dig_nxt[3:0];
        endcase
        lit     = (state_nxt == ON) && !act_blank_nxt[2'd3 - idx_nxt];
        dig_nxt = lit ? (4'b1000 >> idx_nxt) : 4'b0000;
        seg_nxt = lit ? decode(nib) : 7'b0000000;
        dp_nxt  = lit && act_dp_nxt[2'd3 - idx_nxt];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            state      <= (GHOST == 0) ? ON : GAP;
            pend_dig   <= 16'h0000;
            pend_dp    <= 4'b0000;
            pend_blank <= 4'b1111;
            act_dig    <= 16'h0000;
            act_dp     <= 4'b0000;
            act_blank  <= 4'b1111;
            dig_q      <= {4{DIG_INV}};
            seg_q      <= {7{SEG_INV}};
            dp_q       <= SEG_INV;
            frame_done <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            state      <= state_nxt;
            pend_dig   <= pend_dig_nxt;
            pend_dp    <= pend_dp_nxt;
            pend_blank <= pend_blank_nxt;
            act_dig    <= act_dig_nxt;
            act_dp     <= act_dp_nxt;
            act_blank  <= act_blank_nxt;
            dig_q      <= dig_nxt ^ {4{DIG_INV}};
            seg_q      <= seg_nxt ^ {7{SEG_INV}};
            dp_q       <= dp_nxt ^ SEG_INV;
            frame_done <= boundary;
        end
    end

    assign bus.SEG_D1     = dig_q[3];
    assign bus.SEG_D2     = dig_q[2];
    assign bus.SEG_D3     = dig_q[1];
    assign bus.SEG_D4     = dig_q[0];
    assign bus.SEG_A      = seg_q[6];
    assign bus.SEG_B      = seg_q[5];
    assign bus.SEG_C      = seg_q[4];
    assign bus.SEG_D      = seg_q[3];
    assign bus.SEG_E      = seg_q[2];
    assign bus.SEG_F      = seg_q[1];
    assign bus.SEG_G      = seg_q[0];
    assign bus.SEG_P      = dp_q;
    assign bus.Frame_done = frame_done;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed bench for seg7_scan_driver (PRESC=8, GHOST=2 and GHOST=0)
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [11:0] log_q [32];

    always #5 clk = ~clk;

    seg7_scan_driver_if b0 ();
    seg7_scan_driver_if b1 ();

    seg7_scan_driver #(.PRESC(8), .GHOST(2), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1))
        u0 (.Clk(clk), .Rst(rst0), .bus(b0));
    seg7_scan_driver #(.PRESC(8), .GHOST(0), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1))
        u1 (.Clk(clk), .Rst(rst1), .bus(b1));

    // {D1,D2,D3,D4, A..G, P} as seen on the pins
    logic [11:0] obs0, obs1;
    assign obs0 = {b0.SEG_D1, b0.SEG_D2, b0.SEG_D3, b0.SEG_D4, b0.SEG_A, b0.SEG_B, b0.SEG_C,
                   b0.SEG_D, b0.SEG_E, b0.SEG_F, b0.SEG_G, b0.SEG_P};
    assign obs1 = {b1.SEG_D1, b1.SEG_D2, b1.SEG_D3, b1.SEG_D4, b1.SEG_A, b1.SEG_B, b1.SEG_C,
                   b1.SEG_D, b1.SEG_E, b1.SEG_F, b1.SEG_G, b1.SEG_P};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_tab(input logic [3:0] h);
        case (h)
            4'h0: seg_tab = 7'b1111110;  4'h1: seg_tab = 7'b0110000;
            4'h2: seg_tab = 7'b1101101;  4'h3: seg_tab = 7'b1111001;
            4'h4: seg_tab = 7'b0110011;  4'h5: seg_tab = 7'b1011011;
            4'h6: seg_tab = 7'b1011111;  4'h7: seg_tab = 7'b1110000;
            4'h8: seg_tab = 7'b1111111;  4'h9: seg_tab = 7'b1111011;
            4'hA: seg_tab = 7'b1110111;  4'hB: seg_tab = 7'b0011111;
            4'hC: seg_tab = 7'b1001110;  4'hD: seg_tab = 7'b0111101;
            4'hE: seg_tab = 7'b1001111;  default: seg_tab = 7'b1000111;
        endcase
    endfunction

    function automatic logic [11:0] exp_out(input int k, input int ghost, input logic [15:0] ed,
                                            input logic [3:0] edp, input logic [3:0] eb);
        int idx;
        int cnt;
        logic lit;
        logic [3:0] nib;
        logic [3:0] dg;
        logic [6:0] sg;
        logic p;
        idx = k / 8;
        cnt = k % 8;
        lit = (cnt >= ghost) && !eb[3-idx];
        nib = ed[4*(3-idx) +: 4];
        dg  = lit ? (4'b1000 >> idx) : 4'b0000;
        sg  = lit ? seg_tab(nib) : 7'b0000000;
        p   = lit && edp[3-idx];
        return ~{dg, sg, p};
    endfunction

    task automatic drive0(input logic ld, input logic [23:0] v);
        b0.Load = ld;
        if (ld) {b0.Digits, b0.Dp_in, b0.Blank_in} = v;
        else    {b0.Digits, b0.Dp_in, b0.Blank_in} = {16'hC0DE, 4'b1010, 4'b0101};
    endtask

    // One 32-cycle frame of u0, checked every cycle; up to two loads at frame-relative cycles.
    task automatic run_frame(input string tag, input logic [15:0] ed, input logic [3:0] edp,
                             input logic [3:0] eb, input logic efd,
                             input int lc1, input logic [23:0] lv1,
                             input int lc2, input logic [23:0] lv2);
        for (int k = 0; k < 32; k++) begin
            log_q[k] = obs0;
            check_eq($sformatf("%s_pins_k%0d", tag, k), {4'h0, obs0}, {4'h0, exp_out(k, 2, ed, edp, eb)});
            check_eq($sformatf("%s_fd_k%0d", tag, k), {15'h0, b0.Frame_done}, {15'h0, (k == 0) ? efd : 1'b0});
            if (k == lc1)      drive0(1'b1, lv1);
            else if (k == lc2) drive0(1'b1, lv2);
            else               drive0(1'b0, 24'h0);
            tick();
        end
    endtask

    initial begin
        drive0(1'b0, 24'h0);
        b1.Load = 1'b0;
        b1.Digits = 16'h0000;
        b1.Dp_in = 4'b0000;
        b1.Blank_in = 4'b0000;

        tick();
        tick();
        check_eq("reset_pins", {4'h0, obs0}, 16'h0FFF);
        check_eq("reset_fd", {15'h0, b0.Frame_done}, 16'h0000);
        rst0 = 1'b0;

        run_frame("fA", 16'h0000, 4'b0000, 4'b1111, 1'b0,
                  12, {16'h1234, 4'b0100, 4'b0000}, -1, 24'h0);
        run_frame("fB", 16'h1234, 4'b0100, 4'b0000, 1'b1,
                  5, {16'hAAAA, 4'b0000, 4'b0000}, 20, {16'h5555, 4'b0000, 4'b0000});
        check_eq("fB_gap_k1", {4'h0, log_q[1]}, 16'h0FFF);
        check_eq("fB_d1_k2", {4'h0, log_q[2]}, 16'h079F);
        check_eq("fB_d2gap_k8", {4'h0, log_q[8]}, 16'h0FFF);
        check_eq("fB_d2dp_k10", {4'h0, log_q[10]}, 16'h0B24);
        check_eq("fB_d3_k18", {4'h0, log_q[18]}, 16'h0D0D);
        run_frame("fC", 16'h5555, 4'b0000, 4'b0000, 1'b1,
                  10, {16'h0000, 4'b0000, 4'b0000}, 31, {16'hFFFF, 4'b0000, 4'b0000});
        check_eq("fC_d1_k2", {4'h0, log_q[2]}, 16'h0749);
        run_frame("fD", 16'hFFFF, 4'b0000, 4'b0000, 1'b1,
                  3, {16'h9B0E, 4'b0001, 4'b0010}, -1, 24'h0);
        check_eq("fD_d4_k26", {4'h0, log_q[26]}, 16'h0E71);
        run_frame("fE", 16'h9B0E, 4'b0001, 4'b0010, 1'b1,
                  7, {16'h7A6D, 4'b1000, 4'b0000}, -1, 24'h0);
        check_eq("fE_d3dark_k20", {4'h0, log_q[20]}, 16'h0FFF);
        check_eq("fE_d4dp_k26", {4'h0, log_q[26]}, 16'h0E60);
        run_frame("fF", 16'h7A6D, 4'b1000, 4'b0000, 1'b1, -1, 24'h0, -1, 24'h0);
        check_eq("fF_d1dp_k2", {4'h0, log_q[2]}, 16'h071E);

        // GHOST=0 instance
        tick();
        rst1 = 1'b0;
        b1.Load = 1'b1;
        b1.Digits = 16'h1234;
        tick();
        b1.Load = 1'b0;
        b1.Digits = 16'hC0DE;
        for (int c = 1; c < 32; c++) begin
            check_eq($sformatf("g0_fd_c%0d", c), {15'h0, b1.Frame_done}, 16'h0000);
            tick();
        end
        check_eq("g0_fd_c32", {15'h0, b1.Frame_done}, 16'h0001);
        for (int k = 0; k <= 20; k++) begin
            check_eq($sformatf("g0_pins_k%0d", k), {4'h0, obs1}, {4'h0, exp_out(k, 0, 16'h1234, 4'b0000, 4'b0000)});
            check_eq($sformatf("g0_onehot_k%0d", k), 16'($countones(~obs1[11:8])), 16'd1);
            if (k < 20) tick();
        end
        rst1 = 1'b1;
        tick();
        check_eq("g0_rst_pins", {4'h0, obs1}, 16'h0FFF);
        check_eq("g0_rst_fd", {15'h0, b1.Frame_done}, 16'h0000);
        rst1 = 1'b0;
        b1.Load = 1'b1;
        b1.Digits = 16'h1234;
        for (int c = 0; c < 32; c++) begin
            check_eq($sformatf("g0r_fd_c%0d", c), {15'h0, b1.Frame_done}, 16'h0000);
            check_eq($sformatf("g0r_pins_c%0d", c), {4'h0, obs1}, 16'h0FFF);
            tick();
            b1.Load = 1'b0;
        end
        check_eq("g0r_fd_c32", {15'h0, b1.Frame_done}, 16'h0001);
        check_eq("g0r_d1_c32", {12'h0, obs1[11:8]}, 16'h0007);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
